// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared widths, Q1.7 first-quadrant twiddle tables and the
//                saturation helper for the MDC FFT datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TW_W_DEF   = 9;
    localparam int SAT_IN_W   = 48;

    localparam logic signed [TW_W_DEF-1:0] COS_Q1 [0:7] = '{
        9'sd128, 9'sd126, 9'sd118, 9'sd106, 9'sd91, 9'sd71, 9'sd49, 9'sd25
    };
    localparam logic signed [TW_W_DEF-1:0] SIN_Q1 [0:7] = '{
        9'sd0, 9'sd25, 9'sd49, 9'sd71, 9'sd91, 9'sd106, 9'sd118, 9'sd126
    };

    // Clamp v to the signed range of a w-bit word; caller truncates to w bits.
    function automatic logic signed [SAT_IN_W-1:0] sat(
        input logic signed [SAT_IN_W-1:0] v,
        input int                         w
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        hi = (SAT_IN_W'(1) <<< (w - 1)) - SAT_IN_W'(1);
        lo = -hi - SAT_IN_W'(1);
        if (v > hi)
            sat = hi;
        else if (v < lo)
            sat = lo;
        else
            sat = v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_lut.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_lut
//  Description : Combinational W32^k lookup for k = 0..15 built from the
//                first-quadrant table with a half-plane fold.
//  Revision    : 1.0  initial release
// ============================================================================
module twiddle_lut
    import fft_pkg::*;
#(
    parameter int TW_W = TW_W_DEF
) (
    input  logic [3:0]      k,
    output logic [TW_W-1:0] wr,
    output logic [TW_W-1:0] wi
);

    logic [2:0]             w_idx;
    logic signed [TW_W-1:0] w_cos;
    logic signed [TW_W-1:0] w_sin;

    always_comb begin
        w_idx = k[2:0];
        w_cos = TW_W'(COS_Q1[w_idx]);
        w_sin = TW_W'(SIN_Q1[w_idx]);
        wr    = w_cos;
        wi    = -w_sin;
        // Second half-plane: W^(k'+8) = -j * W^k'
        if (k[3]) begin
            wr = -w_sin;
            wi = -w_cos;
        end
    end

endmodule
`default_nettype wire

// File: rtl/twiddle_cmul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_cmul_stage
//  Description : Twiddle sequencer and 3-cycle rounded/saturated complex
//                multiplier for one radix-2 DIF stage of the 32-point MDC FFT.
//  Revision    : 1.0  initial release
// ============================================================================
module twiddle_cmul_stage
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF,
    parameter int STAGE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_last,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im
);

    localparam int         PROD_W = DATA_W + TW_W;
    localparam int         SUM_W  = PROD_W + 1;
    localparam logic [3:0] C_MASK = 4'((16 >> STAGE) - 1);

    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_use;
    logic [3:0]      w_k;
    logic [TW_W-1:0] w_wr;
    logic [TW_W-1:0] w_wi;

    assign w_cnt_use = in_sof ? 4'd0 : r_cnt;
    assign w_k       = (w_cnt_use & C_MASK) << STAGE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= 4'd0;
        else if (in_valid)
            r_cnt <= w_cnt_use + 4'd1;
    end

    twiddle_lut #(.TW_W(TW_W)) u_lut (
        .k  (w_k),
        .wr (w_wr),
        .wi (w_wi)
    );

    // S1: sample and twiddle
    logic                     r1_valid, r1_sof, r1_last;
    logic signed [DATA_W-1:0] r1_re, r1_im;
    logic signed [TW_W-1:0]   r1_wr, r1_wi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_sof   <= 1'b0;
            r1_last  <= 1'b0;
            r1_re    <= '0;
            r1_im    <= '0;
            r1_wr    <= '0;
            r1_wi    <= '0;
        end else begin
            r1_valid <= in_valid;
            r1_sof   <= in_valid & in_sof;
            r1_last  <= in_valid & (w_cnt_use == 4'd15);
            if (in_valid) begin
                r1_re <= in_re;
                r1_im <= in_im;
                r1_wr <= w_wr;
                r1_wi <= w_wi;
            end
        end
    end

    // S2: partial products
    logic                     r2_valid, r2_sof, r2_last;
    logic signed [PROD_W-1:0] r2_rr, r2_ii, r2_ri, r2_ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_sof   <= 1'b0;
            r2_last  <= 1'b0;
            r2_rr    <= '0;
            r2_ii    <= '0;
            r2_ri    <= '0;
            r2_ir    <= '0;
        end else begin
            r2_valid <= r1_valid;
            r2_sof   <= r1_sof;
            r2_last  <= r1_last;
            if (r1_valid) begin
                r2_rr <= PROD_W'(r1_re) * PROD_W'(r1_wr);
                r2_ii <= PROD_W'(r1_im) * PROD_W'(r1_wi);
                r2_ri <= PROD_W'(r1_re) * PROD_W'(r1_wi);
                r2_ir <= PROD_W'(r1_im) * PROD_W'(r1_wr);
            end
        end
    end

    // S3: combine, round half-up, saturate
    logic signed [SUM_W-1:0] w_pr, w_pi, w_rnd_re, w_rnd_im;

    assign w_pr     = SUM_W'(r2_rr) - SUM_W'(r2_ii);
    assign w_pi     = SUM_W'(r2_ri) + SUM_W'(r2_ir);
    assign w_rnd_re = (w_pr + SUM_W'(64)) >>> 7;
    assign w_rnd_im = (w_pi + SUM_W'(64)) >>> 7;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= r2_valid;
            out_sof   <= r2_sof;
            out_last  <= r2_last;
            if (r2_valid) begin
                out_re <= DATA_W'(sat(SAT_IN_W'(w_rnd_re), DATA_W));
                out_im <= DATA_W'(sat(SAT_IN_W'(w_rnd_im), DATA_W));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_cmul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_cmul_stage
//  Description : Scoreboard bench driving a STAGE=0 and a STAGE=2 instance
//                from one stimulus stream.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_twiddle_cmul_stage;

    localparam int DW = 16;
    localparam int TW = 9;

    typedef struct {
        int re;
        int im;
        bit sof;
        bit last;
        int due;
    } exp_t;

    typedef struct {
        int re;
        int im;
        bit sof;
        bit last;
    } cap_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;

    logic          w_valid [2];
    logic          w_sof   [2];
    logic          w_last  [2];
    logic [DW-1:0] w_re    [2];
    logic [DW-1:0] w_im    [2];

    exp_t q0[$];
    exp_t q2[$];
    cap_t cap0[$];
    cap_t cap2[$];
    int   last_re [2];
    int   last_im [2];
    int   m_cnt;
    int   cyc;
    int   n_tests;
    int   n_fail;

    int cos_t [8] = '{128, 126, 118, 106, 91, 71, 49, 25};
    int sin_t [8] = '{0, 25, 49, 71, 91, 106, 118, 126};

    twiddle_cmul_stage #(.DATA_W(DW), .TW_W(TW), .STAGE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im),
        .out_valid(w_valid[0]), .out_sof(w_sof[0]), .out_last(w_last[0]),
        .out_re(w_re[0]), .out_im(w_im[0])
    );

    twiddle_cmul_stage #(.DATA_W(DW), .TW_W(TW), .STAGE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im),
        .out_valid(w_valid[1]), .out_sof(w_sof[1]), .out_last(w_last[1]),
        .out_re(w_re[1]), .out_im(w_im[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int rnd_sat(input longint p);
        longint r;
        r = (p + 64) >>> 7;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic model(input int stage, input int cnt, input int xr, input int xi,
                         output int yr, output int yi);
        int k, wr, wi;
        k = (cnt % (16 >> stage)) << stage;
        if (k < 8) begin
            wr = cos_t[k];
            wi = -sin_t[k];
        end else begin
            wr = -sin_t[k-8];
            wi = -cos_t[k-8];
        end
        yr = rnd_sat(longint'(xr) * wr - longint'(xi) * wi);
        yi = rnd_sat(longint'(xr) * wi + longint'(xi) * wr);
    endtask

    task automatic drive(input bit v, input bit sof, input int xr, input int xi);
        int   use_cnt;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = sof;
        in_re    = DW'(xr);
        in_im    = DW'(xi);
        if (v) begin
            use_cnt = sof ? 0 : m_cnt;
            m_cnt   = (use_cnt + 1) % 16;
            e.sof   = sof;
            e.last  = (use_cnt == 15);
            e.due   = cyc + 3;
            model(0, use_cnt, xr, xi, e.re, e.im);
            q0.push_back(e);
            model(2, use_cnt, xr, xi, e.re, e.im);
            q2.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (6) drive(0, 0, 0, 0);
        chk_eq("drain_q0", q0.size(), 0);
        chk_eq("drain_q2", q2.size(), 0);
    endtask

    task automatic cmp(input int d, input exp_t e);
        cap_t c;
        c.re   = int'($signed(w_re[d]));
        c.im   = int'($signed(w_im[d]));
        c.sof  = w_sof[d];
        c.last = w_last[d];
        chk_eq($sformatf("d%0d_due", d), cyc, e.due);
        chk_eq($sformatf("d%0d_re", d), c.re, e.re);
        chk_eq($sformatf("d%0d_im", d), c.im, e.im);
        chk_eq($sformatf("d%0d_sof", d), int'(c.sof), int'(e.sof));
        chk_eq($sformatf("d%0d_last", d), int'(c.last), int'(e.last));
        last_re[d] = c.re;
        last_im[d] = c.im;
        if (d == 0) cap0.push_back(c);
        else        cap2.push_back(c);
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (w_valid[d]) begin
                    if ((d == 0 ? q0.size() : q2.size()) == 0) begin
                        chk_eq($sformatf("d%0d_spurious", d), 1, 0);
                    end else begin
                        m_e = (d == 0) ? q0.pop_front() : q2.pop_front();
                        cmp(d, m_e);
                    end
                end else begin
                    chk_eq($sformatf("d%0d_hold_re", d), int'($signed(w_re[d])), last_re[d]);
                    chk_eq($sformatf("d%0d_hold_im", d), int'($signed(w_im[d])), last_im[d]);
                    if (d == 0 && q0.size() > 0 && q0[0].due <= cyc) begin
                        chk_eq("d0_missing", 0, 1);
                        void'(q0.pop_front());
                    end
                    if (d == 1 && q2.size() > 0 && q2[0].due <= cyc) begin
                        chk_eq("d1_missing", 0, 1);
                        void'(q2.pop_front());
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("rst_valid_d%0d", d), int'(w_valid[d]), 0);
            chk_eq($sformatf("rst_sof_d%0d", d), int'(w_sof[d]), 0);
            chk_eq($sformatf("rst_last_d%0d", d), int'(w_last[d]), 0);
            chk_eq($sformatf("rst_re_d%0d", d), int'(w_re[d]), 0);
            chk_eq($sformatf("rst_im_d%0d", d), int'(w_im[d]), 0);
            last_re[d] = 0;
            last_im[d] = 0;
        end
        q0.delete();
        q2.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp4_re [4] = '{128, 91, 0, -91};
    int exp4_im [4] = '{0, -91, -128, -91};

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        m_cnt    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        last_re  = '{0, 0};
        last_im  = '{0, 0};
        apply_reset();
        repeat (2) drive(0, 0, 0, 0);

        // Test 1: unit-real input over a full frame
        cap0.delete(); cap2.delete();
        drive(1, 1, 1000, 0);
        repeat (15) drive(1, 0, 1000, 0);
        drain();
        chk_eq("t1_count", cap0.size(), 16);
        if (cap0.size() == 16) begin
            chk_eq("t1_k0_re", cap0[0].re, 1000);
            chk_eq("t1_k0_im", cap0[0].im, 0);
            chk_eq("t1_k2_re", cap0[2].re, 922);
            chk_eq("t1_k2_im", cap0[2].im, -383);
            chk_eq("t1_k8_re", cap0[8].re, 0);
            chk_eq("t1_k8_im", cap0[8].im, -1000);
            for (int i = 0; i < 16; i++)
                chk_eq($sformatf("t1_last%0d", i), int'(cap0[i].last), (i == 15) ? 1 : 0);
        end

        // Test 2: k=8 exact -j rotation
        cap0.delete(); cap2.delete();
        drive(1, 1, 0, 0);
        repeat (7) drive(1, 0, 0, 0);
        drive(1, 0, 100, 50);
        drain();
        chk_eq("t2_count", cap0.size(), 9);
        if (cap0.size() == 9) begin
            chk_eq("t2_re", cap0[8].re, 50);
            chk_eq("t2_im", cap0[8].im, -100);
        end

        // Test 3: saturation at k=4
        cap0.delete(); cap2.delete();
        drive(1, 1, 0, 0);
        repeat (3) drive(1, 0, 0, 0);
        drive(1, 0, -32768, -32768);
        drain();
        chk_eq("t3_count", cap0.size(), 5);
        if (cap0.size() == 5) begin
            chk_eq("t3_re", cap0[4].re, -32768);
            chk_eq("t3_im", cap0[4].im, 0);
        end

        // Test 4: STAGE=2 twiddle cycle
        cap0.delete(); cap2.delete();
        drive(1, 1, 128, 0);
        repeat (15) drive(1, 0, 128, 0);
        drain();
        chk_eq("t4_count", cap2.size(), 16);
        if (cap2.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk_eq($sformatf("t4_re%0d", i), cap2[i].re, exp4_re[i % 4]);
                chk_eq($sformatf("t4_im%0d", i), cap2[i].im, exp4_im[i % 4]);
            end
        end

        // Test 5: bubbles (sof during a bubble is ignored) and mid-frame sof
        cap0.delete(); cap2.delete();
        drive(1, 1, 10, 1);
        for (int i = 1; i < 6; i++) begin
            if (i % 2 == 1) drive(0, 1, 7, 7);
            drive(1, 0, 10 * (i + 1), i + 1);
        end
        drive(1, 1, 300, -200);
        drive(0, 0, 0, 0);
        drive(1, 0, 400, 100);
        drive(1, 0, -500, 250);
        drain();
        chk_eq("t5_count", cap0.size(), 9);
        if (cap0.size() == 9) begin
            chk_eq("t5_sof0", int'(cap0[0].sof), 1);
            chk_eq("t5_re6", cap0[6].re, 300);
            chk_eq("t5_im6", cap0[6].im, -200);
            chk_eq("t5_sof6", int'(cap0[6].sof), 1);
            chk_eq("t5_sof7", int'(cap0[7].sof), 0);
        end

        // Test 6: reset with three samples in flight
        cap0.delete(); cap2.delete();
        drive(1, 1, 500, 500);
        drive(1, 0, 600, -600);
        drive(1, 0, -700, 700);
        apply_reset();
        repeat (5) drive(0, 0, 0, 0);
        chk_eq("t6_no_stale", cap0.size() + cap2.size(), 0);
        drive(1, 1, 1000, 0);
        repeat (15) drive(1, 0, 1000, 0);
        drain();
        chk_eq("t6_count", cap0.size(), 16);
        if (cap0.size() == 16) begin
            chk_eq("t6_k2_re", cap0[2].re, 922);
            chk_eq("t6_last15", int'(cap0[15].last), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
